// File: rtl/spi_slave.sv
// SPI responder oversampled by the system clock: all four CPOL/CPHA modes,
// MSB-first words, back-to-back words under one chip select, valid/ready local side.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic [1:0]            mode,
    input  logic                  sck,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_s, cs_s, mosi_s;
    logic sck_p, rise_q, fall_q, mosi_q, cs_q;
    logic [1:0] mode_q;
    logic lead_evt, trail_evt, sample_evt, shift_evt;

    logic [DATA_WIDTH-1:0] hold_data, tx_sr, rx_sr;
    logic                  hold_full, und_pend, copy;
    logic [CW-1:0]         cnt;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // cs synchronizer resets to deselected so reset release cannot look like a cs fall.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_p     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_p     <= sck_s;
            rise_q    <= sck_s & ~sck_p;
            fall_q    <= ~sck_s & sck_p;
            mosi_q    <= mosi_s;
            cs_q      <= cs_s;
        end
    end

    assign lead_evt   = mode_q[1] ? fall_q : rise_q;
    assign trail_evt  = mode_q[1] ? rise_q : fall_q;
    assign sample_evt = mode_q[0] ? trail_evt : lead_evt;
    assign shift_evt  = mode_q[0] ? lead_evt : trail_evt;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) state <= IDLE;
        else         state <= next_state;
    end

    // NOTE: next_state gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!cs_q) next_state = LOAD;
            LOAD:  next_state = SHIFT;
            SHIFT: begin
                if (cs_q)
                    next_state = IDLE;
                else if (sample_evt && cnt == CW'(DATA_WIDTH - 1))
                    next_state = DONE;
            end
            DONE:  next_state = cs_q ? IDLE : SHIFT;
            default: next_state = IDLE;
        endcase
    end

    // A reload in DONE only counts as underrun once the next word really starts,
    // i.e. at its first sample edge; a clean cs exit right after DONE is not an underrun.
    always_comb begin
        busy        = (state != IDLE);
        miso_oe     = (state != IDLE);
        rx_valid    = (state == DONE);
        frame_err   = (state == SHIFT) && cs_q && (cnt != '0);
        tx_underrun = ((state == LOAD) && !hold_full) ||
                      ((state == SHIFT) && !cs_q && und_pend && sample_evt && (cnt == '0));
    end

    assign tx_ready = ~hold_full;
    assign copy     = (state == LOAD) || ((state == DONE) && !cs_q);

    // The copy sees the old holding contents; a same-cycle load needs tx_ready already high.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            if (copy)
                hold_full <= 1'b0;
            if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            mode_q   <= 2'b00;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cnt      <= '0;
            miso     <= 1'b0;
            und_pend <= 1'b0;
            rx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mode_q   <= mode;
                    miso     <= 1'b0;
                    cnt      <= '0;
                    und_pend <= 1'b0;
                end
                LOAD, DONE: begin
                    cnt <= '0;
                    if (copy) begin
                        tx_sr    <= hold_full ? hold_data : '0;
                        miso     <= hold_full ? hold_data[DATA_WIDTH-1] : 1'b0;
                        rx_sr    <= '0;
                        und_pend <= (state == DONE) && !hold_full;
                    end
                end
                SHIFT: begin
                    if (!cs_q) begin
                        if (sample_evt) begin
                            rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_q};
                            cnt   <= cnt + CW'(1);
                            if (cnt == CW'(DATA_WIDTH - 1))
                                rx_data <= {rx_sr[DATA_WIDTH-2:0], mosi_q};
                            if (cnt == '0)
                                und_pend <= 1'b0;
                        end
                        // cnt==0 marks either the pre-loaded MSB (CPHA=1) or the edge after the last sample.
                        if (shift_evt && cnt != '0) begin
                            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                            miso  <= tx_sr[DATA_WIDTH-2];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bench-side SPI master, rx scoreboard queue,
// pulse counters for rx_valid / tx_underrun / frame_err.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         srst_n;
    logic [1:0]   mode;
    logic         sck, cs, mosi;
    logic         miso, miso_oe;
    logic [W-1:0] tx_data;
    logic         tx_valid, tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid, tx_underrun, frame_err, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int rx_cnt   = 0;
    int und_cnt  = 0;
    int ferr_cnt = 0;

    logic [W-1:0] exp_rx[$];

    spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .srst_n      (srst_n),
        .mode        (mode),
        .sck         (sck),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            if (exp_rx.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else                    check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
        if (tx_underrun) und_cnt++;
        if (frame_err)   ferr_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_push(input logic [W-1:0] d);
        int t = 0;
        while (!tx_ready && t < 500) begin
            clks(1);
            t++;
        end
        if (t >= 500) check("tx_ready_timeout", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        clks(1);
        tx_valid = 1'b0;
    endtask

    // Bench-side master: drives nbits MSB-first and captures miso at the master's sample edge.
    task automatic spi_xfer(input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rx);
        logic cpol, cpha;
        cpol = mode[1];
        cpha = mode[0];
        rx = '0;
        for (int i = W - 1; i >= W - nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i];
                clks(HALF);
                rx[i] = miso;
                sck = ~cpol;
                clks(HALF);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = tx[i];
                clks(HALF);
                rx[i] = miso;
                sck = cpol;
                clks(HALF);
            end
        end
        clks(HALF);
    endtask

    task automatic frame(input logic [W-1:0] mtx, input logic [W-1:0] exp_slave);
        logic [W-1:0] got;
        exp_rx.push_back(mtx);
        cs = 1'b0;
        clks(10);
        spi_xfer(mtx, W, got);
        check("miso_word", 32'(got), 32'(exp_slave));
        clks(4);
        cs = 1'b1;
        clks(8);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] got;
        int rx0, und0, fe0;
        logic [W-1:0] b2b_m[3];
        logic [W-1:0] b2b_s[3];
        b2b_m = '{8'hF0, 8'h0F, 8'hAA};
        b2b_s = '{8'h11, 8'h22, 8'h33};

        srst_n = 1'b0; mode = 2'b00; sck = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        clks(5);
        srst_n = 1'b1;
        clks(5);

        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'(rx_cnt + und_cnt + ferr_cnt), 32'd0);

        // Mode 0 basic exchange.
        rx0 = rx_cnt;
        tx_push(8'hA5);
        check("tx_ready_loaded", 32'(tx_ready), 32'd0);
        exp_rx.push_back(8'h3C);
        cs = 1'b0;
        clks(10);
        check("busy_sel", 32'(busy), 32'd1);
        check("miso_oe_sel", 32'(miso_oe), 32'd1);
        check("tx_ready_after_load", 32'(tx_ready), 32'd1);
        check("miso_msb_at_cs", 32'(miso), 32'd1);
        spi_xfer(8'h3C, W, got);
        check("miso_word_m0", 32'(got), 32'hA5);
        clks(4);
        cs = 1'b1;
        clks(8);
        check("rx_pulses_m0", 32'(rx_cnt - rx0), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);

        // All four modes, sck idle level follows CPOL.
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            sck  = mode[1];
            clks(6);
            tx_push(8'h7E);
            frame(8'h81, 8'h7E);
        end

        // Back-to-back words under one cs, holding register refilled on the fly.
        mode = 2'b00; sck = 1'b0;
        clks(6);
        rx0 = rx_cnt; und0 = und_cnt;
        tx_push(b2b_s[0]);
        cs = 1'b0;
        clks(10);
        for (int k = 0; k < 3; k++) begin
            if (k < 2) tx_push(b2b_s[k+1]);
            exp_rx.push_back(b2b_m[k]);
            spi_xfer(b2b_m[k], W, got);
            check("miso_word_b2b", 32'(got), 32'(b2b_s[k]));
        end
        clks(4);
        cs = 1'b1;
        clks(8);
        check("rx_pulses_b2b", 32'(rx_cnt - rx0), 32'd3);
        check("underrun_b2b", 32'(und_cnt - und0), 32'd0);

        // Empty holding register at cs fall.
        und0 = und_cnt;
        frame(8'h55, 8'h00);
        check("underrun_once", 32'(und_cnt - und0), 32'd1);

        // cs raised after 5 bits.
        rx0 = rx_cnt; fe0 = ferr_cnt;
        cs = 1'b0;
        clks(10);
        spi_xfer(8'h33, 5, got);
        cs = 1'b1;
        clks(10);
        check("frame_err_cycles", 32'(ferr_cnt - fe0), 32'd1);
        check("rx_pulses_ferr", 32'(rx_cnt - rx0), 32'd0);
        check("rx_data_kept", 32'(rx_data), 32'h55);
        check("miso_oe_ferr", 32'(miso_oe), 32'd0);
        check("busy_ferr", 32'(busy), 32'd0);

        // Reset asserted mid-word.
        tx_push(8'hA5);
        cs = 1'b0;
        clks(10);
        spi_xfer(8'hFF, 3, got);
        srst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_miso_oe", 32'(miso_oe), 32'd0);
        check("arst_miso", 32'(miso), 32'd0);
        check("arst_tx_ready", 32'(tx_ready), 32'd1);
        check("arst_rx_data", 32'(rx_data), 32'd0);
        cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        clks(4);
        srst_n = 1'b1;
        clks(6);
        tx_push(8'h3C);
        frame(8'hC3, 8'h3C);
        check("rx_after_reset", 32'(rx_data), 32'hC3);

        check("scoreboard_empty", 32'(exp_rx.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target/responder, system-clock oversampled. Samples external sck/cs/mosi through synchronizers and drives miso.
- Supports all four CPOL/CPHA modes. Transfers are MSB-first, DATA_WIDTH bits per word; multiple back-to-back words are allowed while cs is held low.
- Presents received words to the local core and takes transmit words from it over valid/ready.
- Pairs with the team's spi_master on the same bus.

Parameters:
DATA_WIDTH, 8, bits per SPI word, >=2
SYNC_STAGES, 2, synchronizer flops on sck/cs/mosi, >=2

Ports:
clk  in  1  system clock; sck frequency must be <= clk/8
srst_n  in  1  asynchronous active-low reset
mode  in  2  {CPOL,CPHA}; sampled only in IDLE
sck  in  1  SPI clock from master, asynchronous
cs  in  1  chip select, active low, asynchronous
mosi  in  1  serial data from master
miso  out  1  serial data to master
miso_oe  out  1  miso output enable; 1 only while selected
tx_data  in  DATA_WIDTH  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  tx holding register empty
rx_data  out  DATA_WIDTH  last complete received word
rx_valid  out  1  one-cycle pulse, rx_data updated
tx_underrun  out  1  one-cycle pulse, word started with empty holding register
frame_err  out  1  one-cycle pulse, cs deasserted mid-word
busy  out  1  1 while selected (state != IDLE)

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0, busy=0; shift registers, bit counter and holding register cleared.
- sck/cs/mosi each pass through SYNC_STAGES flops. Edge detect adds a 1-flop delay. Input-to-event latency is SYNC_STAGES+1 clk.
- Leading edge = sck transition away from CPOL; trailing edge = transition back to CPOL.
- CPHA=0: sample mosi on leading edge, shift miso on trailing edge. The first bit must be on miso when cs falls.
- CPHA=1: shift miso on leading edge, sample mosi on trailing edge.
- Holding register: load when tx_valid&&tx_ready; tx_ready falls the next cycle. It is emptied (tx_ready=1) when copied into the tx shift register.
- FSM:
  - IDLE: miso_oe=0. mode is latched here. On synchronized cs fall, go to LOAD.
  - LOAD (1 clk): copy the holding register into the tx shift register. If it is empty, load all-zeros and pulse tx_underrun. Drive miso=MSB, set miso_oe=1, clear the bit counter, go to SHIFT.
  - SHIFT: on each sample edge, shift mosi into the rx shift register LSB and increment the counter. On each shift edge, advance the tx shift register and update miso, except for the shift edge that follows the last sample.
    - When the counter reaches DATA_WIDTH: go to DONE.
  - DONE (1 clk): rx_data <= rx shift register; rx_valid=1 this cycle. Clear the counter.
    - If cs is still low, reload from the holding register exactly as in LOAD (underrun rule applies) and go to SHIFT. The next word's MSB must be on miso before the next leading edge.
    - If cs is high, go to IDLE.
- rx_valid pulses in the cycle after the sample edge of bit DATA_WIDTH-1 is detected.
- cs rise in SHIFT with counter!=0: discard the partial word, no rx_valid, pulse frame_err, go to IDLE, miso_oe=0 next clk.
- cs rise with counter==0: clean exit to IDLE, no error.
- Simultaneous tx_valid load and LOAD/DONE copy in the same cycle: the copy takes the old register contents. The new word is accepted into the emptied register only if tx_ready was 1 that cycle; otherwise tx_valid is held by the sender.
- sck edges while cs is high are ignored. A mode change while busy has no effect until IDLE.
- rx_data holds its value until the next completed word. There is no rx backpressure: a word not consumed is overwritten.

Test Plan:
- Mode 0, tx_data=0xA5 preloaded, master sends 0x3C: miso bit stream 1,0,1,0,0,1,0,1; rx_data=0x3C with a single rx_valid pulse; tx_ready back to 1 after LOAD.
- All four modes with master sending 0x81 and slave sending 0x7E: correct bits exchanged both ways in every mode; sck idle level varied with CPOL.
- Back-to-back: cs held low for 3 words, slave tx 0x11,0x22,0x33 supplied via tx_valid, master sends 0xF0,0x0F,0xAA: three rx_valid pulses with matching data, no underrun.
- Empty holding register at cs fall: miso drives 0x00, tx_underrun pulses once, rx still captures master data 0x55.
- cs raised after 5 bits: frame_err=1 for one clk, no rx_valid, rx_data keeps its previous value, miso_oe=0, busy=0.
- srst_n asserted mid-word (bit 3): all outputs return to reset values asynchronously. The next full frame after release receives 0xC3 correctly.
